// File: rtl/ibuf_pkg.sv
// Shared defaults and entry layout for the instruction buffer between fetch and decode.
package ibuf_pkg;

    localparam int DEPTH_DEF = 4;
    localparam int INS_W_DEF = 32;
    localparam int PC_W_DEF  = 30;

    typedef struct packed {
        logic [INS_W_DEF-1:0] ins;
        logic [PC_W_DEF-1:0]  pc;
    } ibuf_entry_t;

endpackage

// File: rtl/ibuf_mem.sv
// Entry storage for ibuf: one synchronous write port, one asynchronous read port, no reset.
module ibuf_mem #(
    parameter int DEPTH = 4,
    parameter int W     = 62
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ibuf.sv
// Instruction buffer between fetch and decode: DEPTH-entry FIFO with flush, no fall-through.
module ibuf
    import ibuf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int INS_W = INS_W_DEF,
    parameter int PC_W  = PC_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [INS_W-1:0]         in_ins,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [INS_W-1:0]         out_ins,
    output logic [PC_W-1:0]          out_pc,
    input  logic                     out_ready,
    input  logic                     flush,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int ENT_W = INS_W + PC_W;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [CW-1:0]    cnt;
    logic [ENT_W-1:0] rd_data;
    logic             push;
    logic             pop;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high and flush is low; ready and valid depend only on registered occupancy.
    assign in_ready  = (cnt < FULL);
    assign out_valid = (cnt != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (push) begin
                tail <= tail + AW'(1);
            end
            if (pop) begin
                head <= head + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    ibuf_mem #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (tail),
        .wdata ({in_ins, in_pc}),
        .raddr (head),
        .rdata (rd_data)
    );

    // Storage is never reset, so mask the read data whenever nothing is buffered.
    assign out_ins = out_valid ? rd_data[ENT_W-1:PC_W] : '0;
    assign out_pc  = out_valid ? rd_data[PC_W-1:0]     : '0;

endmodule

// File: tb/tb_ibuf.sv
// Directed bench for ibuf: table-driven vectors plus hand sequences, backed by a queue scoreboard.
module tb_ibuf;
    import ibuf_pkg::*;

    localparam int DEPTH = 4;
    localparam int ENT_W = $bits(ibuf_entry_t);

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_ins;
    logic [29:0] in_pc;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_ins;
    logic [29:0] out_pc;
    logic        out_ready;
    logic        flush;
    logic [2:0]  count;

    int n_pass  = 0;
    int n_total = 0;

    logic [ENT_W-1:0] exp_q[$];

    ibuf dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ins    (in_ins),
        .in_pc     (in_pc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ins   (out_ins),
        .out_pc    (out_pc),
        .out_ready (out_ready),
        .flush     (flush),
        .count     (count)
    );

    // clock
    always #5 clk = ~clk;

    function automatic logic [31:0] ins_of(input logic [29:0] pc);
        return (pc == 30'd0) ? 32'h2008_0005 : (32'hA000_0000 | {2'b00, pc});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle; the scoreboard checks popped data before the edge and state after it.
    task automatic cycle(input logic iv, input logic [29:0] pc, input logic ordy,
                         input logic fl, input logic rst);
        logic do_push;
        logic do_pop;
        reset     = rst;
        in_valid  = iv;
        in_pc     = pc;
        in_ins    = ins_of(pc);
        out_ready = ordy;
        flush     = fl;
        #1;
        do_pop  = (exp_q.size() != 0) && ordy && !fl && !rst;
        do_push = iv && (exp_q.size() < DEPTH) && !fl && !rst;
        if (rst || fl) begin
            exp_q.delete();
        end else begin
            if (do_pop) begin
                chk("sb_pop_data", {2'b00, out_ins, out_pc}, {2'b00, exp_q[0]});
                void'(exp_q.pop_front());
            end
            if (do_push) begin
                exp_q.push_back({ins_of(pc), pc});
            end
        end
        @(posedge clk);
        #1;
        chk("sb_count", 64'(count), 64'(exp_q.size()));
        chk("sb_out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("sb_head", {2'b00, out_ins, out_pc}, {2'b00, exp_q[0]});
        end else begin
            chk("sb_head_zero", {2'b00, out_ins, out_pc}, 64'd0);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [29:0] pc;
        logic        ordy;
        logic        fl;
        logic        rst;
        int          e_cnt;
        logic        e_ov;
        logic        e_ir;
        logic [29:0] e_pc;
    } vec_t;

    vec_t vecs[26];

    initial begin
        // iv, pc, ordy, fl, rst | count, out_valid, in_ready, head pc
        vecs[0]  = '{1'b0, 30'd0,  1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 30'd0};
        vecs[1]  = '{1'b1, 30'd0,  1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 30'd0};
        vecs[2]  = '{1'b1, 30'd1,  1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 30'd0};
        vecs[3]  = '{1'b1, 30'd2,  1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 30'd0};
        vecs[4]  = '{1'b1, 30'd3,  1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 30'd0};
        vecs[5]  = '{1'b1, 30'd4,  1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 30'd0};
        vecs[6]  = '{1'b0, 30'd0,  1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1, 30'd1};
        vecs[7]  = '{1'b0, 30'd0,  1'b1, 1'b0, 1'b0, 2, 1'b1, 1'b1, 30'd2};
        vecs[8]  = '{1'b0, 30'd0,  1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 30'd3};
        vecs[9]  = '{1'b0, 30'd0,  1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 30'd0};
        for (int i = 10; i < 15; i++) begin
            vecs[i] = '{1'b0, 30'd0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 30'd0};
        end
        vecs[15] = '{1'b1, 30'd10, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 30'd10};
        vecs[16] = '{1'b1, 30'd11, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 30'd10};
        vecs[17] = '{1'b1, 30'd12, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 30'd10};
        vecs[18] = '{1'b1, 30'd13, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 30'd10};
        vecs[19] = '{1'b0, 30'd0,  1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 30'd0};
        vecs[20] = '{1'b1, 30'd20, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1, 30'd20};
        vecs[21] = '{1'b1, 30'd21, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 30'd20};
        vecs[22] = '{1'b1, 30'd22, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 30'd20};
        vecs[23] = '{1'b1, 30'd23, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b0, 30'd20};
        vecs[24] = '{1'b1, 30'd24, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1, 30'd21};
        vecs[25] = '{1'b1, 30'd25, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b1, 30'd22};

        reset = 1'b1; in_valid = 1'b0; in_ins = '0; in_pc = '0;
        out_ready = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 26; i++) begin
            cycle(vecs[i].iv, vecs[i].pc, vecs[i].ordy, vecs[i].fl, vecs[i].rst);
            chk($sformatf("v%0d_count", i), 64'(count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
            chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
            chk($sformatf("v%0d_out_pc", i), 64'(out_pc), 64'(vecs[i].e_pc));
            chk($sformatf("v%0d_out_ins", i), 64'(out_ins),
                vecs[i].e_ov ? 64'(ins_of(vecs[i].e_pc)) : 64'd0);
        end

        // steady push+pop at count=2 across several pointer wraps
        cycle(1'b0, 30'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 30'h30, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 30'h31, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("ss%0d_pop_pc", i), 64'(out_pc), 64'(30'h30 + 30'(i)));
            cycle(1'b1, 30'h32 + 30'(i), 1'b1, 1'b0, 1'b0);
            chk($sformatf("ss%0d_count", i), 64'(count), 64'd2);
        end

        // flush with concurrent push and pop: everything dropped
        cycle(1'b1, 30'h3C, 1'b0, 1'b0, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd3);
        cycle(1'b1, 30'h100, 1'b1, 1'b1, 1'b0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_out_ins", 64'(out_ins), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        cycle(1'b1, 30'h101, 1'b0, 1'b0, 1'b0);
        chk("post_flush_head", 64'(out_pc), 64'h101);
        cycle(1'b0, 30'd0, 1'b1, 1'b0, 1'b0);
        chk("post_flush_empty", 64'(out_valid), 64'd0);

        // held head stays stable while decode stalls
        cycle(1'b1, 30'h55, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 30'h56, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 30'h3FF, 1'b0, 1'b0, 1'b0);
            chk($sformatf("stall%0d_pc", i), 64'(out_pc), 64'h55);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ibuf.md
IBUF -- requirements
Module: ibuf

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered instruction entries (power of two, 2..16).
REQ-002 Parameter INS_W, default 32, instruction width.
REQ-003 Parameter PC_W, default 30, word-address PC width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  fetch stage presents an instruction.
REQ-007 in_ins  input  INS_W  fetched instruction word.
REQ-008 in_pc  input  PC_W  word address of in_ins.
REQ-009 in_ready  output  1  buffer accepts a push this cycle.
REQ-010 out_valid  output  1  head entry available to decode.
REQ-011 out_ins  output  INS_W  head instruction.
REQ-012 out_pc  output  PC_W  head PC.
REQ-013 out_ready  input  1  decode consumes head this cycle.
REQ-014 flush  input  1  taken branch/jump; discard all buffered entries.
REQ-015 count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-016 Push occurs when in_valid && in_ready && !flush; {in_ins,in_pc} is written at the tail and the tail advances.
REQ-017 Pop occurs when out_valid && out_ready && !flush; the head advances.
REQ-018 in_ready SHALL equal (count < DEPTH), combinational from registered state only; no dependence on out_ready.
REQ-019 out_valid SHALL equal (count != 0); no fall-through: a push is visible at the output one cycle later at the earliest.
REQ-020 out_ins/out_pc SHALL present the head entry when out_valid=1 and SHALL be all-zero when out_valid=0.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-022 Full (count=DEPTH): in_ready=0; a pop that cycle frees one slot; in_ready rises next cycle.
REQ-023 Empty (count=0): out_ready ignored; count never underflows.
REQ-024 Head and tail pointers SHALL wrap from DEPTH-1 to 0 modulo DEPTH.
REQ-025 flush=1 SHALL, at the next edge, set count=0 and both pointers to 0, ignoring any push or pop that cycle; in_valid data in a flush cycle is dropped.
REQ-026 Held inputs: in_ins/in_pc are sampled only on a push edge; out_* SHALL remain stable while out_valid=1 and out_ready=0.

Reset
REQ-027 reset=1 SHALL at the next edge set count=0, head=0, tail=0; thus in_ready=1, out_valid=0, out_ins=0, out_pc=0.
REQ-028 reset SHALL take priority over flush, push and pop; reset mid-stream discards all entries.
REQ-029 Storage array contents are not reset; they are unobservable because of REQ-020.

Structure
REQ-030 Shared package ibuf_pkg SHALL hold INS_W, PC_W, DEPTH defaults and the entry typedef {ins, pc}.
REQ-031 Storage SHALL be a sub-module ibuf_mem (DEPTH x (INS_W+PC_W), one write port, one asynchronous read port); pointer/count logic lives in ibuf.

Verification
REQ-032 Reset, then push pc=0x0000_0000 ins=0x2008_0005 -> next cycle out_valid=1, out_pc=0, out_ins=0x2008_0005, count=1.
REQ-033 Push 4 entries pc=0..3 with out_ready=0 -> count=4, in_ready=0; a fifth in_valid is not accepted; drain yields pc 0,1,2,3 in order.
REQ-034 At count=2, push and pop same cycle for 10 cycles -> count stays 2, popped pcs strictly sequential, pointers wrap with no loss.
REQ-035 With 3 entries, assert flush together with in_valid (pc=0x100) and out_ready -> next cycle count=0, out_valid=0, out_ins=0; pc 0x100 never appears.
REQ-036 With count=4, assert reset together with out_ready -> next cycle count=0, in_ready=1, out_valid=0, out_pc=0.
REQ-037 Empty buffer, out_ready=1 for 5 cycles -> count remains 0, out_valid remains 0.
